// File: rtl/sio_pkg.sv
// Shared types and constants for the POKEY SIO peer port (RX/TX FSM states, frame geometry).
package sio_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Bits needed for a down-counter holding 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sio_rx_sampler.sv
// Receive half of the SIO peer: 2-flop synchronizer, start detection, mid-bit sampling, RX FSM
// and the byte handshake. Break detection is compiled in only when SIO_BREAK_DET_EN is defined.
module sio_rx_sampler
  import sio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 93,
  parameter int BREAK_BITS   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sod_in,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_break
);

  localparam int             CW        = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || BREAK_BITS < 1) begin : g_bad_cfg
    $error("sio_rx_sampler: CLKS_PER_BIT must be >= 4 and BREAK_BITS >= 1");
  end

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 sod_meta_q, sod_s_q, sod_prev_q;
  logic                 cnt_expire, byte_done;

  assign cnt_expire = (cnt_q == {CW{1'b0}});

  // RX FSM next state: sample in the middle of each bit, counting from the start-bit edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_expire ? cnt_q : cnt_q - CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (sod_prev_q && !sod_s_q) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_expire && !sod_s_q) begin
          state_d   = RX_DATA;
          cnt_d     = FULL_LOAD;
          bit_idx_d = 3'd0;
        end else if (cnt_expire) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_expire) begin
          shift_d = {sod_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          if (bit_idx_q == LAST_BIT) begin
            state_d   = RX_STOP;
            bit_idx_d = 3'd0;
          end else begin
            state_d   = RX_DATA;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (cnt_expire && sod_s_q) begin
          byte_done = 1'b1;
          state_d   = RX_IDLE;
        end else if (cnt_expire) begin
          frame_err_d = 1'b1;
          state_d     = RX_WAIT_HIGH;
        end else begin
          state_d = RX_STOP;
        end
      end
      RX_WAIT_HIGH: begin
        if (sod_s_q) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_WAIT_HIGH;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Handshake: an ack on the completion cycle frees the slot in time for the new byte.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = rx_ack ? 1'b0 : overrun_q;
    if (rx_ack && valid_q) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (byte_done && (!valid_q || rx_ack)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (byte_done) begin
      overrun_d = 1'b1;
    end else begin
      data_d = data_q;
    end
  end

  // RX state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sod_meta_q  <= 1'b1;
      sod_s_q     <= 1'b1;
      sod_prev_q  <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= {CW{1'b0}};
      bit_idx_q   <= 3'd0;
      shift_q     <= {DATA_BITS{1'b0}};
      data_q      <= {DATA_BITS{1'b0}};
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sod_meta_q  <= sod_in;
      sod_s_q     <= sod_meta_q;
      sod_prev_q  <= sod_s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;

`ifdef SIO_BREAK_DET_EN
  localparam int            BREAK_CYCLES = BREAK_BITS * CLKS_PER_BIT;
  localparam int            BW           = cnt_width(BREAK_CYCLES + 1);
  localparam logic [BW-1:0] BREAK_MAX    = BW'(BREAK_CYCLES);

  logic [BW-1:0] low_cnt_q, low_cnt_d;
  logic          break_q, break_d;

  // Saturating low-run counter; any high sample ends the break.
  always_comb begin
    if (sod_s_q) begin
      low_cnt_d = {BW{1'b0}};
      break_d   = 1'b0;
    end else if (low_cnt_q == BREAK_MAX) begin
      low_cnt_d = low_cnt_q;
      break_d   = 1'b1;
    end else begin
      low_cnt_d = low_cnt_q + BW'(1);
      break_d   = (low_cnt_q == BREAK_MAX - BW'(1));
    end
  end

  // Break detector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_cnt_q <= {BW{1'b0}};
      break_q   <= 1'b0;
    end else begin
      low_cnt_q <= low_cnt_d;
      break_q   <= break_d;
    end
  end

  assign rx_break = break_q;
`else
  assign rx_break = 1'b0;
`endif

endmodule

// File: rtl/sio_peer_port.sv
// Device-side endpoint of the POKEY SIO link: 8N1 receiver on sod, 8N1 transmitter on sid.
// Define SIO_BREAK_DET_EN to enable break detection on sod (rx_break is tied low otherwise).
module sio_peer_port
  import sio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 93,
  parameter int BREAK_BITS   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sod_in,
  output logic       sid_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_break
);

  localparam int            CW        = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  sio_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .BREAK_BITS  (BREAK_BITS)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .sod_in      (sod_in),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun),
    .rx_break    (rx_break)
  );

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 sid_q, sid_d;
  logic                 ready_q, ready_d;
  logic                 tx_expire;

  assign tx_expire = (tx_cnt_q == {CW{1'b0}});

  // TX FSM: sid_d is the level for the next cycle, so each bit lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_expire ? tx_cnt_q : tx_cnt_q - CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    sid_d      = sid_q;
    ready_d    = ready_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && ready_q) begin
          tx_shift_d = tx_data;
          tx_cnt_d   = FULL_LOAD;
          sid_d      = 1'b0;
          ready_d    = 1'b0;
          tx_state_d = TX_START;
        end else begin
          sid_d   = 1'b1;
          ready_d = 1'b1;
        end
      end
      TX_START: begin
        if (tx_expire) begin
          sid_d      = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[DATA_BITS-1:1]};
          tx_cnt_d   = FULL_LOAD;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_state_d = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_expire && tx_bit_q == LAST_BIT) begin
          sid_d      = 1'b1;
          tx_cnt_d   = FULL_LOAD;
          tx_state_d = TX_STOP;
        end else if (tx_expire) begin
          sid_d      = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[DATA_BITS-1:1]};
          tx_cnt_d   = FULL_LOAD;
          tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_state_d = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tx_expire) begin
          ready_d    = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_state_d = TX_STOP;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state registers; reset drives the line idle-high immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= {CW{1'b0}};
      tx_bit_q   <= 3'd0;
      tx_shift_q <= {DATA_BITS{1'b0}};
      sid_q      <= 1'b1;
      ready_q    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      sid_q      <= sid_d;
      ready_q    <= ready_d;
    end
  end

  assign sid_out  = sid_q;
  assign tx_ready = ready_q;

endmodule

// File: tb/tb_sio_peer_port.sv
// Self-checking bench for sio_peer_port at CLKS_PER_BIT=8: randomized bytes checked against a
// frame-level reference model (expected line waveform and receive-slot rules).
module tb_sio_peer_port;

  localparam int CPB     = 8;
  localparam int FRAME   = 10 * CPB;
  // Drive index whose following edge samples the stop bit: 2 sync stages, half bit, nine bits.
  localparam int ACK_IDX = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst, sod_drv, loop_en, sod_line, sid_out;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ack, rx_frame_err, rx_overrun, rx_break;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;

  logic       m_valid, m_ovr;
  logic [7:0] m_data;

  assign sod_line = loop_en ? sid_out : sod_drv;

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_frame_err === 1'b1) fe_cnt++;

  sio_peer_port #(.CLKS_PER_BIT(CPB), .BREAK_BITS(10)) dut (
    .clk(clk), .rst(rst), .sod_in(sod_line), .sid_out(sid_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_break(rx_break)
  );

  // Reference model of the single receive slot.
  task automatic model_byte(input logic [7:0] b);
    if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = b;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic model_ack();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    sod_drv = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < FRAME; k++) begin
      sod_drv = f[k / CPB];
      rx_ack  = (k == ack_at);
      @(negedge clk);
    end
    rx_ack = 1'b0;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    model_ack();
    @(negedge clk);
  endtask

  task automatic tx_send_and_check(input logic [7:0] b, input logic keep_valid, input logic [7:0] nxt);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    if (keep_valid) tx_data = nxt;
    else tx_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      checks++;
      if (sid_out !== f[k / CPB] || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL tx_bit byte=%h k=%0d got sid=%b ready=%b want sid=%b ready=0",
                 b, k, sid_out, tx_ready, f[k / CPB]);
      end
      @(negedge clk);
    end
    checks++;
    if (sid_out !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_end byte=%h got sid=%b ready=%b want sid=1 ready=1", b, sid_out, tx_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sod_drv = 1'b1; loop_en = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ack = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({sid_out, tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun, rx_break}
        !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got sid=%b rdy=%b data=%h v=%b fe=%b ovr=%b brk=%b want 1 1 00 0 0 0 0",
               sid_out, tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun, rx_break);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_tx_timing();
    tx_send_and_check(8'h01, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, c;
    a = 8'($urandom()); b = 8'($urandom()); c = 8'($urandom());
    tx_send_and_check(a, 1'b1, b);
    tx_send_and_check(b, 1'b1, c);
    tx_send_and_check(c, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tx_reset();
    tx_data = 8'($urandom()); tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sid_out !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_reset got sid=%b ready=%b want sid=1 ready=1", sid_out, tx_ready);
    end
    rst = 1'b0;
    model_ack();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rx_random();
    logic [7:0] b;
    int fe0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom());
      fe0 = fe_cnt;
      send_frame(b, 1'b1, -1);
      model_byte(b);
      repeat (2) @(negedge clk);
      checks++;
      if (rx_valid !== m_valid || rx_data !== m_data || rx_overrun !== m_ovr || fe_cnt != fe0) begin
        errors++;
        $display("FAIL rx_byte got v=%b d=%h ovr=%b fe=%0d want v=%b d=%h ovr=%b fe=%0d",
                 rx_valid, rx_data, rx_overrun, fe_cnt - fe0, m_valid, m_data, m_ovr, 0);
      end
      do_ack();
      checks++;
      if (rx_valid !== m_valid) begin
        errors++;
        $display("FAIL rx_ack_clear got v=%b want v=%b", rx_valid, m_valid);
      end
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, -1);
    model_byte(8'h11);
    send_frame(8'h22, 1'b1, -1);
    model_byte(8'h22);
    repeat (2) @(negedge clk);
    checks++;
    if (rx_valid !== m_valid || rx_data !== m_data || rx_overrun !== m_ovr) begin
      errors++;
      $display("FAIL overrun got v=%b d=%h ovr=%b want v=%b d=%h ovr=%b",
               rx_valid, rx_data, rx_overrun, m_valid, m_data, m_ovr);
    end
    do_ack();
    checks++;
    if (rx_valid !== m_valid || rx_overrun !== m_ovr) begin
      errors++;
      $display("FAIL overrun_ack got v=%b ovr=%b want v=%b ovr=%b", rx_valid, rx_overrun, m_valid, m_ovr);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] b1, b2;
    b1 = 8'($urandom());
    b2 = b1 ^ 8'h5A;
    send_frame(b1, 1'b1, -1);
    model_byte(b1);
    send_frame(b2, 1'b1, ACK_IDX);
    model_ack();
    model_byte(b2);
    repeat (2) @(negedge clk);
    checks++;
    if (rx_valid !== m_valid || rx_data !== m_data || rx_overrun !== m_ovr) begin
      errors++;
      $display("FAIL ack_same_cycle got v=%b d=%h ovr=%b want v=%b d=%h ovr=%b",
               rx_valid, rx_data, rx_overrun, m_valid, m_data, m_ovr);
    end
    do_ack();
  endtask

  task automatic test_framing();
    int fe0;
    logic [7:0] b;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1);
    repeat (40) @(negedge clk);
    checks++;
    if (fe_cnt != fe0 + 1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_err got pulses=%0d v=%b want pulses=1 v=0", fe_cnt - fe0, rx_valid);
    end
    sod_drv = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (fe_cnt != fe0 + 1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_release got pulses=%0d v=%b want pulses=1 v=0", fe_cnt - fe0, rx_valid);
    end
    b = 8'($urandom());
    send_frame(b, 1'b1, -1);
    model_byte(b);
    repeat (2) @(negedge clk);
    checks++;
    if (rx_valid !== m_valid || rx_data !== m_data) begin
      errors++;
      $display("FAIL frame_recover got v=%b d=%h want v=%b d=%h", rx_valid, rx_data, m_valid, m_data);
    end
    do_ack();
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    sod_drv = 1'b0;
    repeat (2) @(negedge clk);
    sod_drv = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL glitch got v=%b fe=%0d want v=0 fe=0", rx_valid, fe_cnt - fe0);
    end
  endtask

  task automatic test_break();
    int fe0;
    logic exp_brk;
`ifdef SIO_BREAK_DET_EN
    exp_brk = 1'b1;
`else
    exp_brk = 1'b0;
`endif
    fe0 = fe_cnt;
    sod_drv = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (rx_break !== exp_brk) begin
      errors++;
      $display("FAIL break_hold got %b want %b", rx_break, exp_brk);
    end
    sod_drv = 1'b1;
    for (int i = 0; i < 3 && rx_break !== 1'b0; i++) @(negedge clk);
    checks++;
    if (rx_break !== 1'b0) begin
      errors++;
      $display("FAIL break_release got %b want 0", rx_break);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (fe_cnt != fe0 + 1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL break_frame_err got pulses=%0d v=%b want pulses=1 v=0", fe_cnt - fe0, rx_valid);
    end
  endtask

  task automatic test_loopback();
    int n;
    int fe0;
    fe0 = fe_cnt;
    loop_en = 1'b1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (rx_valid !== 1'b1 && n < 150) begin
      @(negedge clk);
      n++;
    end
    model_byte(8'hA5);
    checks++;
    if (n < 75 || n > 90) begin
      errors++;
      $display("FAIL loop_latency got %0d cycles want 75..90", n);
    end
    checks++;
    if (rx_valid !== m_valid || rx_data !== m_data || rx_overrun !== m_ovr || fe_cnt != fe0) begin
      errors++;
      $display("FAIL loopback got v=%b d=%h ovr=%b fe=%0d want v=%b d=%h ovr=%b fe=0",
               rx_valid, rx_data, rx_overrun, fe_cnt - fe0, m_valid, m_data, m_ovr);
    end
    repeat (10) @(negedge clk);
    loop_en = 1'b0;
    do_ack();
  endtask

  initial begin
    test_reset();
    test_tx_timing();
    test_back_to_back();
    test_tx_reset();
    test_rx_random();
    test_overrun();
    test_simultaneous();
    test_framing();
    test_glitch();
    test_break();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
